// File: rtl/ik_swift_pkg.sv
// Shared constants and types for the ik_swift Avalon-MM bridge.
package ik_swift_pkg;

    // Core fixed-point word width; bits above 31 travel in the hi register word.
    localparam int DATA_W = 36;

    // Word addresses on the Avalon-MM slave port.
    localparam logic [6:0] ADDR_CTRL     = 7'h00;
    localparam logic [6:0] ADDR_STATUS   = 7'h01;
    localparam logic [6:0] ADDR_CYCLES   = 7'h02;
    localparam logic [6:0] ADDR_IN_BASE  = 7'h10;
    localparam logic [6:0] ADDR_OUT_BASE = 7'h40;

    // CTRL write bits.
    localparam int CTRL_START  = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS read bits.
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;
    localparam int ST_WERR = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } bridge_state_t;

    // True when addr falls inside a lo/hi pair region of 'words' entries starting at base.
    function automatic logic in_region(input logic [6:0] addr, input logic [6:0] base,
                                       input int words);
        return (int'(addr) >= int'(base)) && (int'(addr) < int'(base) + 2 * words);
    endfunction

endpackage

// File: rtl/ik_swift_word_bank.sv
// N-word register bank: 32-bit lo / narrow hi writes, per-word parallel load,
// and a lo/hi read mux that sign-extends the hi part to 32 bits.
module ik_swift_word_bank #(
    parameter int N      = 12,
    parameter int DATA_W = 36,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  wr_hi,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [31:0]           wr_data,
    input  logic [N-1:0]          load_en,
    input  logic [N*DATA_W-1:0]   load_data,
    input  logic [IDX_W-1:0]      rd_idx,
    input  logic                  rd_hi,
    output logic [31:0]           rd_data,
    output logic [N*DATA_W-1:0]   words
);

    logic [DATA_W-1:0] mem [N];
    logic [DATA_W-1:0] rd_word;

    // Word storage: a parallel load takes priority over a bus write to the same word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (load_en[i]) begin
                    mem[i] <= load_data[i*DATA_W +: DATA_W];
                end else if (wr_en && (int'(wr_idx) == i)) begin
                    if (wr_hi) begin
                        mem[i][DATA_W-1:32] <= wr_data[DATA_W-33:0];
                    end else begin
                        mem[i][31:0] <= wr_data;
                    end
                end
            end
        end
    end

    // Read mux: out-of-range indices read as zero; hi reads are sign-extended.
    always_comb begin
        rd_word = '0;
        rd_data = '0;
        if (int'(rd_idx) < N) begin
            rd_word = mem[rd_idx];
        end
        if (rd_hi) begin
            rd_data = {{(64-DATA_W){rd_word[DATA_W-1]}}, rd_word[DATA_W-1:32]};
        end else begin
            rd_data = rd_word[31:0];
        end
    end

    // Flat view of all words for the core side.
    for (genvar g = 0; g < N; g++) begin : g_words
        assign words[g*DATA_W +: DATA_W] = mem[g];
    end

endmodule

// File: rtl/ik_swift_avalon_bridge.sv
// Avalon-MM slave that loads ik_swift inputs, launches a run, times it and
// latches the results for readback, with timeout and level interrupt.
module ik_swift_avalon_bridge
    import ik_swift_pkg::*;
#(
    parameter int DATA_W    = 36,
    parameter int IN_WORDS  = 12,
    parameter int OUT_WORDS = 6,
    parameter int TIMEOUT   = 4096,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [6:0]                    address,
    input  logic                          chipselect,
    input  logic                          write,
    input  logic [31:0]                   writedata,
    input  logic                          read,
    output logic [31:0]                   readdata,
    output logic                          irq,
    output logic                          core_start,
    output logic [IN_WORDS*DATA_W-1:0]    core_in,
    input  logic                          core_done,
    input  logic [OUT_WORDS*DATA_W-1:0]   core_out
);

    localparam int IN_IDX_W  = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
    localparam int OUT_IDX_W = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

    // Valid/ready contract: this slave is always ready. A bus cycle is valid when
    // chipselect is high together with exactly one of write/read; a read returns
    // data on readdata one clock later, and there is no waitrequest.
    logic wr_cyc;
    logic rd_cyc;
    assign wr_cyc = chipselect & write;
    assign rd_cyc = chipselect & read;

    bridge_state_t          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cycles_q;
    logic                   done_q, err_q, werr_q, irq_en_q;
    logic                   busy;
    logic                   done_evt, tmo_evt;

    // Address decode.
    logic                   ctrl_wr, start_wr, clr_wr;
    logic                   in_hit, out_hit;
    logic [6:0]             in_off, out_off;
    logic [IN_IDX_W-1:0]    in_idx;
    logic [OUT_IDX_W-1:0]   out_idx;
    logic                   in_wr;

    assign ctrl_wr  = wr_cyc && (address == ADDR_CTRL);
    assign start_wr = ctrl_wr && writedata[CTRL_START];
    assign clr_wr   = ctrl_wr && writedata[CTRL_CLR];
    assign in_hit   = in_region(address, ADDR_IN_BASE, IN_WORDS);
    assign out_hit  = in_region(address, ADDR_OUT_BASE, OUT_WORDS);
    assign in_off   = address - ADDR_IN_BASE;
    assign out_off  = address - ADDR_OUT_BASE;
    assign in_idx   = IN_IDX_W'(in_off >> 1);
    assign out_idx  = OUT_IDX_W'(out_off >> 1);
    assign in_wr    = wr_cyc && in_hit;

    assign busy       = (state_q != IDLE);
    assign core_start = (state_q == LAUNCH);
    assign irq        = (done_q | err_q) & irq_en_q;

    // Input registers feed the core continuously; bus writes are dropped while busy.
    logic [31:0] in_rd;
    logic [31:0] out_rd;
    logic [OUT_WORDS*DATA_W-1:0] out_words_unused;

    ik_swift_word_bank #(.N(IN_WORDS), .DATA_W(DATA_W)) u_in_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (in_wr && !busy),
        .wr_hi     (in_off[0]),
        .wr_idx    (in_idx),
        .wr_data   (writedata),
        .load_en   ('0),
        .load_data ('0),
        .rd_idx    (in_idx),
        .rd_hi     (in_off[0]),
        .rd_data   (in_rd),
        .words     (core_in)
    );

    // Result registers load all words together on a completed run.
    ik_swift_word_bank #(.N(OUT_WORDS), .DATA_W(DATA_W)) u_out_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (1'b0),
        .wr_hi     (1'b0),
        .wr_idx    ('0),
        .wr_data   ('0),
        .load_en   ({OUT_WORDS{done_evt}}),
        .load_data (core_out),
        .rd_idx    (out_idx),
        .rd_hi     (out_off[0]),
        .rd_data   (out_rd),
        .words     (out_words_unused)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and run-completion events; done beats a coincident timeout.
    always_comb begin
        state_d  = state_q;
        done_evt = 1'b0;
        tmo_evt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_wr) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = RUN;
            end
            RUN: begin
                if (core_done) begin
                    done_evt = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    tmo_evt = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Run counter counts cycles since core_start (zero in the LAUNCH cycle); status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            cycles_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            werr_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && start_wr) begin
                cnt_q <= '0;
            end else if (busy) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (clr_wr) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
                werr_q <= 1'b0;
            end
            if (state_q == IDLE && start_wr) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (done_evt) begin
                done_q   <= 1'b1;
                cycles_q <= cnt_q;
            end
            if (tmo_evt) begin
                err_q <= 1'b1;
            end
            if (in_wr && busy) begin
                werr_q <= 1'b1;
            end
        end
    end

    // IRQ enable is rewritten by every CTRL write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= 1'b0;
        end else if (ctrl_wr) begin
            irq_en_q <= writedata[CTRL_IRQ_EN];
        end
    end

    // Registered read data: one-cycle latency, unmapped addresses read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readdata <= '0;
        end else if (rd_cyc) begin
            if (address == ADDR_CTRL) begin
                readdata <= {29'b0, irq_en_q, 2'b0};
            end else if (address == ADDR_STATUS) begin
                readdata <= {28'b0, werr_q, err_q, done_q, busy};
            end else if (address == ADDR_CYCLES) begin
                readdata <= 32'(cycles_q);
            end else if (in_hit) begin
                readdata <= in_rd;
            end else if (out_hit) begin
                readdata <= out_rd;
            end else begin
                readdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ik_swift_avalon_bridge.sv
// Directed bench for ik_swift_avalon_bridge with a hand-driven core stub.
module tb_ik_swift_avalon_bridge;

    localparam int DW  = 36;
    localparam int INW = 12;
    localparam int OTW = 6;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [6:0]           address = '0;
    logic                 chipselect = 1'b0;
    logic                 write = 1'b0;
    logic [31:0]          writedata = '0;
    logic                 read = 1'b0;
    logic [31:0]          readdata;
    logic                 irq;
    logic                 core_start;
    logic [INW*DW-1:0]    core_in;
    logic                 core_done = 1'b0;
    logic [OTW*DW-1:0]    core_out = '0;

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0;

    ik_swift_avalon_bridge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .read       (read),
        .readdata   (readdata),
        .irq        (irq),
        .core_start (core_start),
        .core_in    (core_in),
        .core_done  (core_done),
        .core_out   (core_out)
    );

    // Clock.
    always #5 clk = ~clk;

    // Count cycles in which core_start is high.
    always @(posedge clk) begin
        if (core_start) start_cnt++;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus tasks start and end at a falling edge; each takes one cycle.
    task automatic bus_write(input logic [6:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [6:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; read = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic read_check(input string tag, input logic [6:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check_val(tag, 64'(d), 64'(exp));
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!core_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 64'(core_start), 64'd1);
    endtask

    initial begin : main
        int n;
        int s0;

        // Reset.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. Reset state.
        check_val("rst_irq", 64'(irq), 64'd0);
        check_val("rst_core_start", 64'(core_start), 64'd0);
        check_val("rst_core_in", 64'(core_in[DW-1:0]), 64'd0);
        read_check("rst_status", 7'h01, 32'h0);
        read_check("rst_cycles", 7'h02, 32'h0);
        read_check("rst_out0_hi", 7'h41, 32'h0);
        read_check("rst_ctrl", 7'h00, 32'h0);

        // 2. Input write and sign-extended readback.
        bus_write(7'h10, 32'h0000_0001);
        bus_write(7'h11, 32'h0000_0008);
        read_check("in0_lo", 7'h10, 32'h0000_0001);
        read_check("in0_hi", 7'h11, 32'hFFFF_FFF8);
        check_val("core_in0", 64'(core_in[DW-1:0]), 64'h8_0000_0001);
        bus_write(7'h26, 32'hAAAA_5555);
        bus_write(7'h27, 32'h0000_0007);
        read_check("in11_hi", 7'h27, 32'h0000_0007);
        check_val("core_in11", 64'(core_in[11*DW +: DW]), 64'h7_AAAA_5555);
        read_check("unmapped", 7'h30, 32'h0);

        // 3. Normal run, done 20 cycles after core_start.
        bus_write(7'h00, 32'h1);
        wait_start("run1_start");
        read_check("run1_busy", 7'h01, 32'h1);
        repeat (19) @(negedge clk);
        core_out = '0;
        core_out[DW-1:0] = 36'h1_2345_6789;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        core_out = '0;
        read_check("run1_status", 7'h01, 32'h2);
        read_check("run1_cycles", 7'h02, 32'd20);
        read_check("run1_out0_lo", 7'h40, 32'h2345_6789);
        read_check("run1_out0_hi", 7'h41, 32'h0000_0001);
        check_val("run1_starts", 64'(start_cnt), 64'd1);

        // 4. Timeout with IRQ enabled.
        bus_write(7'h00, 32'h4);
        read_check("ctrl_irq_en", 7'h00, 32'h4);
        bus_write(7'h00, 32'h5);
        n = 0;
        while (!irq && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_val("tmo_irq", 64'(irq), 64'd1);
        check_val("tmo_cycles_to_irq", 64'(n), 64'd4096);
        read_check("tmo_status", 7'h01, 32'h4);
        read_check("tmo_out0_lo", 7'h40, 32'h2345_6789);
        bus_write(7'h00, 32'h6);
        check_val("clr_irq", 64'(irq), 64'd0);
        read_check("clr_status", 7'h01, 32'h0);
        check_val("tmo_starts", 64'(start_cnt), 64'd2);

        // 5. Writes while busy, done coinciding with the timeout cycle.
        bus_write(7'h00, 32'h1);
        bus_write(7'h10, 32'h0000_DEAD);
        bus_write(7'h00, 32'h1);
        read_check("busy_in0_lo", 7'h10, 32'h0000_0001);
        read_check("busy_status", 7'h01, 32'h9);
        repeat (4091) @(negedge clk);
        core_out = '0;
        core_out[DW-1:0] = 36'hF_0000_0042;
        core_out[5*DW +: DW] = 36'h0_8000_0000;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        core_out = '0;
        read_check("edge_status", 7'h01, 32'hA);
        read_check("edge_cycles", 7'h02, 32'd4095);
        read_check("edge_out0_lo", 7'h40, 32'h0000_0042);
        read_check("edge_out0_hi", 7'h41, 32'hFFFF_FFFF);
        read_check("edge_out5_lo", 7'h4A, 32'h8000_0000);
        read_check("edge_out5_hi", 7'h4B, 32'h0);
        check_val("edge_starts", 64'(start_cnt), 64'd3);

        // 6. Asynchronous reset mid-run, then a late core_done.
        bus_write(7'h00, 32'h2);
        bus_write(7'h00, 32'h1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("arst_core_start", 64'(core_start), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = start_cnt;
        core_out = '1;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        core_out = '0;
        read_check("arst_status", 7'h01, 32'h0);
        read_check("arst_out0_lo", 7'h40, 32'h0);
        read_check("arst_out0_hi", 7'h41, 32'h0);
        repeat (5) @(negedge clk);
        check_val("arst_no_start", 64'(start_cnt), 64'(s0));
        check_val("arst_total_starts", 64'(start_cnt), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
